mem_stage: RTL and testbench

Memory-access stage controller that consumes the EX/MEM pipeline register outputs and drives the data-memory handshake. It stalls the upstream pipeline registers while a load or store is outstanding, resolves taken branches into a flush/redirect pulse, and presents registered write-back fields to the MEM/WB register. It sits between EX/MEM and MEM/WB; its `stall` output is inverted to form `Write` on the IF/ID, ID/EX and EX/MEM registers.

---
 rtl/mem_stage.sv | 119 +++++++++++
 tb/tb_mem_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MEM-stage controller; stalls upstream while a load/store is outstanding, drives data-memory handshake, resolves taken branches, registers write-back fields.
//   Ports: clk, rst (async, active-high); EX/MEM inputs (BPC_in, gprDes_in, aluOut_in, gprB_in, zero_in, pcSel_in, memR_in, memW_in, regW_in, memToR_in);
//   stall (comb); branch_taken/flush/branch_target; dm_req/dm_we/dm_addr/dm_wdata/dm_rdata/dm_ack; wb_regW/wb_gprDes/wb_data; err.
//   Optional macro MEMSTG_TIMEOUT_EN: abort a WAIT after TIMEOUT unacknowledged cycles with an err pulse.
module mem_stage #(
  parameter int TIMEOUT = 15,
  parameter int TO_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] BPC_in,
  input  logic [4:0]  gprDes_in,
  input  logic [31:0] aluOut_in,
  input  logic [31:0] gprB_in,
  input  logic        zero_in,
  input  logic        pcSel_in,
  input  logic        memR_in,
  input  logic        memW_in,
  input  logic        regW_in,
  input  logic        memToR_in,
  output logic        stall,
  output logic        branch_taken,
  output logic        flush,
  output logic [31:0] branch_target,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        wb_regW,
  output logic [4:0]  wb_gprDes,
  output logic [31:0] wb_data,
  output logic        err
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_nx;
  logic mem_op, expire, br;
  logic l_regW, l_memToR;
  logic [4:0] l_des;
  assign mem_op = memR_in | memW_in;
  assign br = (state == IDLE) & !mem_op & pcSel_in & zero_in;
`ifdef MEMSTG_TIMEOUT_EN
  logic [TO_W-1:0] cnt;
  assign expire = (state == WAIT) & !dm_ack & (cnt == TO_W'(TIMEOUT));
`else
  assign expire = 1'b0;
`endif
  // rst gates stall so upstream is released the instant reset is asserted
  always_comb begin
    state_nx = state;
    stall = 1'b0;
    if (state == IDLE) begin
      state_nx = mem_op ? WAIT : IDLE;
      stall = mem_op & !rst;
    end else begin
      state_nx = (dm_ack | expire) ? IDLE : WAIT;
      stall = !dm_ack & !expire & !rst;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      dm_req <= 1'b0;
      dm_we <= 1'b0;
      dm_addr <= '0;
      dm_wdata <= '0;
      wb_regW <= 1'b0;
      wb_gprDes <= '0;
      wb_data <= '0;
      branch_taken <= 1'b0;
      flush <= 1'b0;
      branch_target <= '0;
      err <= 1'b0;
      l_regW <= 1'b0;
      l_memToR <= 1'b0;
      l_des <= '0;
`ifdef MEMSTG_TIMEOUT_EN
      cnt <= '0;
`endif
    end else begin
      state <= state_nx;
      branch_taken <= br;
      flush <= br;
      if (br) branch_target <= BPC_in;
      err <= expire;
      if (state == IDLE) begin
        if (mem_op) begin
          dm_req <= 1'b1;
          dm_we <= memW_in;
          dm_addr <= aluOut_in;
          dm_wdata <= gprB_in;
          l_regW <= regW_in;
          l_memToR <= memToR_in;
          l_des <= gprDes_in;
          wb_regW <= 1'b0;
`ifdef MEMSTG_TIMEOUT_EN
          cnt <= '0;
`endif
        end else begin
          wb_regW <= regW_in;
          wb_gprDes <= gprDes_in;
          wb_data <= aluOut_in;
        end
      end else if (dm_ack) begin
        dm_req <= 1'b0;
        wb_regW <= l_regW;
        wb_gprDes <= l_des;
        wb_data <= l_memToR ? dm_rdata : dm_addr;
      end else begin
        wb_regW <= 1'b0;
        if (expire) dm_req <= 1'b0;
`ifdef MEMSTG_TIMEOUT_EN
        else cnt <= cnt + 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage.
module tb_mem_stage;
  logic clk = 0, rst;
  logic [31:0] BPC_in, aluOut_in, gprB_in, dm_rdata;
  logic [4:0] gprDes_in;
  logic zero_in, pcSel_in, memR_in, memW_in, regW_in, memToR_in, dm_ack;
  logic stall, branch_taken, flush, dm_req, dm_we, wb_regW, err;
  logic [31:0] branch_target, dm_addr, dm_wdata, wb_data;
  logic [4:0] wb_gprDes;
  int n_cmp = 0, n_bad = 0;
  typedef struct packed {logic regW; logic [4:0] des; logic [31:0] data;} wb_t;
  wb_t sb[$];
  mem_stage #(.TIMEOUT(4), .TO_W(4)) dut (
    .clk(clk), .rst(rst), .BPC_in(BPC_in), .gprDes_in(gprDes_in), .aluOut_in(aluOut_in),
    .gprB_in(gprB_in), .zero_in(zero_in), .pcSel_in(pcSel_in), .memR_in(memR_in),
    .memW_in(memW_in), .regW_in(regW_in), .memToR_in(memToR_in), .stall(stall),
    .branch_taken(branch_taken), .flush(flush), .branch_target(branch_target),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .wb_regW(wb_regW), .wb_gprDes(wb_gprDes),
    .wb_data(wb_data), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic clr();
    BPC_in = 0; gprDes_in = 0; aluOut_in = 0; gprB_in = 0; zero_in = 0; pcSel_in = 0;
    memR_in = 0; memW_in = 0; regW_in = 0; memToR_in = 0;
  endtask
  task automatic check_wb(input string tag);
    wb_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_regW"}, 32'(wb_regW), 32'(e.regW));
    chk({tag, "_des"}, 32'(wb_gprDes), 32'(e.des));
    chk({tag, "_data"}, wb_data, e.data);
  endtask
  // Hold the op presented until ack in the ack_at-th dm_req cycle; report stall/req counts.
  task automatic run_mem(input int ack_at, input logic [31:0] rd, output int n_st, output int n_rq,
                         output logic [31:0] a, output logic [31:0] wd, output logic we);
    logic fin;
    n_st = 0; n_rq = 0; fin = 0; a = 0; wd = 0; we = 0;
    for (int c = 0; c < 50 && !fin; c++) begin
      dm_ack = dm_req && (n_rq + 1 == ack_at);
      dm_rdata = dm_ack ? rd : 32'h0;
      #1;
      n_st += int'(stall);
      n_rq += int'(dm_req);
      fin = dm_ack;
      if (fin) begin a = dm_addr; wd = dm_wdata; we = dm_we; end
      step();
      dm_ack = 0; dm_rdata = 0;
    end
    if (fin) clr();
    else chk("ack_bound", 0, 1);
  endtask
  initial begin
    int ns, nr, n_err;
    logic [31:0] a, wd;
    logic we, seen;
    rst = 1; dm_ack = 0; dm_rdata = 0; clr();
    #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_req", 32'(dm_req), 0);
    chk("rst_wb_regW", 32'(wb_regW), 0);
    chk("rst_branch", 32'(branch_taken), 0);
    chk("rst_err", 32'(err), 0);
    step(); step();
    rst = 0;
    // ALU op
    regW_in = 1; gprDes_in = 5; aluOut_in = 32'h1234;
    sb.push_back('{1'b1, 5'd5, 32'h1234});
    #1 chk("alu_stall", 32'(stall), 0);
    step(); clr();
    check_wb("alu");
    // load, ack in 3rd req cycle
    memR_in = 1; memToR_in = 1; regW_in = 1; gprDes_in = 7; aluOut_in = 32'h40;
    sb.push_back('{1'b1, 5'd7, 32'hDEADBEEF});
    run_mem(3, 32'hDEADBEEF, ns, nr, a, wd, we);
    chk("ld_stall_cycles", ns, 3);
    chk("ld_req_cycles", nr, 3);
    chk("ld_addr", a, 32'h40);
    chk("ld_we", 32'(we), 0);
    check_wb("ld");
    // back-to-back load, ack in 2nd req cycle
    memR_in = 1; memToR_in = 1; regW_in = 1; gprDes_in = 9; aluOut_in = 32'h44;
    sb.push_back('{1'b1, 5'd9, 32'h0BADF00D});
    run_mem(2, 32'h0BADF00D, ns, nr, a, wd, we);
    chk("ld2_stall_cycles", ns, 2);
    chk("ld2_req_cycles", nr, 2);
    check_wb("ld2");
    // store, ack in 1st WAIT cycle
    memW_in = 1; gprB_in = 32'hCAFE; aluOut_in = 32'h80; gprDes_in = 3;
    sb.push_back('{1'b0, 5'd3, 32'h80});
    run_mem(1, 32'h0, ns, nr, a, wd, we);
    chk("st_stall_cycles", ns, 1);
    chk("st_req_cycles", nr, 1);
    chk("st_we", 32'(we), 1);
    chk("st_addr", a, 32'h80);
    chk("st_wdata", wd, 32'hCAFE);
    check_wb("st");
    chk("st_req_low", 32'(dm_req), 0);
    // ack in IDLE is ignored
    regW_in = 1; gprDes_in = 4; aluOut_in = 32'h55; dm_ack = 1; dm_rdata = 32'hFFFF;
    sb.push_back('{1'b1, 5'd4, 32'h55});
    step(); clr(); dm_ack = 0; dm_rdata = 0;
    check_wb("idle_ack");
    chk("idle_ack_req", 32'(dm_req), 0);
    // branch taken
    pcSel_in = 1; zero_in = 1; BPC_in = 32'h100;
    #1 chk("br_pre", 32'(branch_taken), 0);
    step(); clr();
    chk("br_taken", 32'(branch_taken), 1);
    chk("br_flush", 32'(flush), 1);
    chk("br_target", branch_target, 32'h100);
    step();
    chk("br_taken_1cyc", 32'(branch_taken), 0);
    chk("br_flush_1cyc", 32'(flush), 0);
    // branch not taken
    pcSel_in = 1; zero_in = 0; BPC_in = 32'h200;
    step(); clr();
    chk("nbr_taken", 32'(branch_taken), 0);
    chk("nbr_target_hold", branch_target, 32'h100);
    // reset during WAIT
    memR_in = 1; memToR_in = 1; regW_in = 1; gprDes_in = 6; aluOut_in = 32'h60;
    step();
    chk("rw_req_pre", 32'(dm_req), 1);
    rst = 1;
    #1;
    chk("rw_req", 32'(dm_req), 0);
    chk("rw_stall", 32'(stall), 0);
    chk("rw_wb_regW", 32'(wb_regW), 0);
    chk("rw_wb_data", wb_data, 0);
    chk("rw_wb_des", 32'(wb_gprDes), 0);
    clr();
    step();
    rst = 0;
    dm_ack = 1; dm_rdata = 32'h12345678;
    step(); dm_ack = 0; dm_rdata = 0;
    chk("rw_late_ack_regW", 32'(wb_regW), 0);
    chk("rw_late_ack_data", wb_data, 0);
    // no ack: abort on timeout, or stall indefinitely
    memR_in = 1; memToR_in = 1; regW_in = 1; gprDes_in = 2; aluOut_in = 32'h90;
`ifdef MEMSTG_TIMEOUT_EN
    ns = 0; nr = 0; seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      #1;
      seen = err;
      if (!seen) begin
        ns += int'(stall);
        nr += int'(dm_req);
        if (!stall) clr();
        step();
      end
    end
    chk("to_err_seen", 32'(seen), 1);
    chk("to_stall_cycles", ns, 5);
    chk("to_req_cycles", nr, 5);
    chk("to_req_drop", 32'(dm_req), 0);
    chk("to_stall_drop", 32'(stall), 0);
    chk("to_wb_regW", 32'(wb_regW), 0);
    n_err = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      n_err += int'(err);
    end
    chk("to_err_once", n_err, 0);
`else
    for (int c = 0; c < 20; c++) step();
    #1;
    chk("noto_stall", 32'(stall), 1);
    chk("noto_req", 32'(dm_req), 1);
    chk("noto_err", 32'(err), 0);
    clr(); rst = 1; step(); rst = 0;
`endif
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
